lif_neuron_array: RTL and testbench

Time-multiplexed array of N_NEURONS leaky integrate-and-fire neurons sharing one leak/integrate/compare datapath. It is the parametrised successor of the single LIF neuron. It adds:
- configurable data width and neuron count
- a refractory period
- saturating arithmetic
- a valid/ready timestep handshake
- membrane readback

It sits between the synaptic current accumulator (upstream) and the spike router (downstream).

---
 rtl/lif_neuron_array.sv | 151 +++++++++++++++
 tb/tb_lif_neuron_array.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons sharing one
// leak/integrate/compare datapath, with refractory hold and membrane readback.
module lif_neuron_array #(
  parameter int unsigned N_NEURONS = 8,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAC_W    = 16,
  parameter int unsigned REFRAC_W  = 4,
  parameter int unsigned IDX_W     = $clog2(N_NEURONS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          step_valid,
  output logic                          step_ready,
  input  logic [N_NEURONS*DATA_W-1:0]   input_current,
  input  logic [FRAC_W-1:0]             leak_factor,
  input  logic [DATA_W-1:0]             threshold,
  input  logic [DATA_W-1:0]             reset_potential,
  input  logic [REFRAC_W-1:0]           refrac_period,
  output logic                          spike_valid,
  input  logic                          spike_ready,
  output logic [N_NEURONS-1:0]          spikes,
  input  logic [IDX_W-1:0]              rd_idx,
  output logic [DATA_W-1:0]             rd_potential
);

  localparam int unsigned PROD_W = DATA_W + FRAC_W;
  localparam int unsigned SUM_W  = DATA_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [N_NEURONS-1:0] acc;

  logic [DATA_W-1:0]    cur_q [N_NEURONS];
  logic [FRAC_W-1:0]    leak_q;
  logic [DATA_W-1:0]    thr_q;
  logic [DATA_W-1:0]    vrst_q;
  logic [REFRAC_W-1:0]  refr_q;

  logic [DATA_W-1:0]    v_mem [N_NEURONS];
  logic [REFRAC_W-1:0]  r_mem [N_NEURONS];

  logic [DATA_W-1:0]    v_cur;
  logic [REFRAC_W-1:0]  r_cur;
  logic [PROD_W-1:0]    prod;
  logic [DATA_W-1:0]    leak;
  logic [SUM_W-1:0]     sum;
  logic [DATA_W-1:0]    sat;
  logic [DATA_W-1:0]    new_v;
  logic [REFRAC_W-1:0]  new_r;
  logic                 fire;
  logic                 we;
  logic [DATA_W-1:0]    rd_next;

  // Shared neuron datapath for the neuron selected by idx
  always_comb begin
    v_cur = v_mem[idx];
    r_cur = r_mem[idx];
    prod  = PROD_W'(v_cur) * PROD_W'(leak_q);
    leak  = prod[PROD_W-1:FRAC_W];
    // leak <= v always, so the subtraction cannot wrap
    sum   = SUM_W'(v_cur) - SUM_W'(leak) + SUM_W'(cur_q[idx]);
    sat   = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
    new_v = v_cur;
    new_r = r_cur;
    fire  = 1'b0;
    if (r_cur != '0) begin
      new_r = r_cur - REFRAC_W'(1);
      new_v = vrst_q;
    end else if (sat >= thr_q) begin
      fire  = 1'b1;
      new_v = vrst_q;
      new_r = refr_q;
    end else begin
      new_v = sat;
    end
  end

  // Readback is write-first against the neuron being updated this cycle
  always_comb begin
    we      = (state == UPDATE);
    rd_next = '0;
    if (32'(rd_idx) < N_NEURONS) begin
      if (we && (rd_idx == idx)) rd_next = new_v;
      else                       rd_next = v_mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      acc          <= '0;
      step_ready   <= 1'b1;
      spike_valid  <= 1'b0;
      spikes       <= '0;
      rd_potential <= '0;
      leak_q       <= '0;
      thr_q        <= '0;
      vrst_q       <= '0;
      refr_q       <= '0;
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        cur_q[i] <= '0;
        v_mem[i] <= '0;
        r_mem[i] <= '0;
      end
    end else begin
      rd_potential <= rd_next;
      if (we) begin
        v_mem[idx] <= new_v;
        r_mem[idx] <= new_r;
        acc[idx]   <= fire;
      end
      case (state)
        IDLE: begin
          if (step_valid) begin
            for (int i = 0; i < int'(N_NEURONS); i++)
              cur_q[i] <= input_current[i*DATA_W +: DATA_W];
            leak_q     <= leak_factor;
            thr_q      <= threshold;
            vrst_q     <= reset_potential;
            refr_q     <= refrac_period;
            acc        <= '0;
            idx        <= '0;
            step_ready <= 1'b0;
            state      <= UPDATE;
          end
        end
        UPDATE: begin
          if (idx == LAST_IDX) state <= DONE;
          else                 idx   <= idx + IDX_W'(1);
        end
        DONE: begin
          // First DONE cycle publishes the vector; it then holds until accepted
          if (!spike_valid) begin
            spike_valid <= 1'b1;
            spikes      <= acc;
          end else if (spike_ready) begin
            spike_valid <= 1'b0;
            step_ready  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array: reset, integrate/fire, refractory hold,
// saturation, backpressure/latency, threshold zero and reset mid-update.
module tb_lif_neuron_array;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int FW = 16;
  localparam int RW = 4;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            step_valid;
  logic            step_ready;
  logic [N*DW-1:0] input_current;
  logic [FW-1:0]   leak_factor;
  logic [DW-1:0]   threshold;
  logic [DW-1:0]   reset_potential;
  logic [RW-1:0]   refrac_period;
  logic            spike_valid;
  logic            spike_ready;
  logic [N-1:0]    spikes;
  logic [IW-1:0]   rd_idx;
  logic [DW-1:0]   rd_potential;

  int n_tests = 0;
  int n_fail  = 0;

  lif_neuron_array #(
    .N_NEURONS(N), .DATA_W(DW), .FRAC_W(FW), .REFRAC_W(RW), .IDX_W(IW)
  ) dut (
    .clk(clk), .reset(reset),
    .step_valid(step_valid), .step_ready(step_ready),
    .input_current(input_current), .leak_factor(leak_factor),
    .threshold(threshold), .reset_potential(reset_potential),
    .refrac_period(refrac_period),
    .spike_valid(spike_valid), .spike_ready(spike_ready), .spikes(spikes),
    .rd_idx(rd_idx), .rd_potential(rd_potential)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic set_cfg(input int cur0, input int lk, input int thr, input int rp, input int rf);
    input_current   = '0;
    input_current[DW-1:0] = DW'(cur0);
    leak_factor     = FW'(lk);
    threshold       = DW'(thr);
    reset_potential = DW'(rp);
    refrac_period   = RW'(rf);
  endtask

  task automatic read_v(input int i, output logic [DW-1:0] v);
    rd_idx = IW'(i);
    @(posedge clk); #1;
    v = rd_potential;
  endtask

  task automatic run_step(output logic [N-1:0] sp);
    int n;
    n = 0;
    while (!step_ready && n < 100) begin @(posedge clk); #1; n++; end
    step_valid = 1'b1;
    @(posedge clk); #1;
    step_valid = 1'b0;
    n = 0;
    while (!spike_valid && n < 100) begin @(posedge clk); #1; n++; end
    if (!spike_valid) check("spike_timeout", 32'(spike_valid), 32'd1);
    sp = spikes;
    spike_ready = 1'b1;
    @(posedge clk); #1;
    spike_ready = 1'b0;
  endtask

  initial begin
    logic [N-1:0]  sp;
    logic [DW-1:0] v;
    int            n;
    int            bad;
    int            exp_v  [7] = '{10000, 19500, 28525, 5000, 5000, 5000, 14750};
    int            exp_sp [7] = '{0, 0, 0, 1, 0, 0, 0};

    step_valid = 1'b0; spike_ready = 1'b0; rd_idx = '0;
    set_cfg(0, 0, 0, 0, 0);

    // Reset then idle
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    check("rst_step_ready", 32'(step_ready), 32'd1);
    check("rst_spike_valid", 32'(spike_valid), 32'd0);
    check("rst_spikes", 32'(spikes), 32'd0);
    for (int i = 0; i < N; i++) begin
      read_v(i, v);
      check($sformatf("rst_v%0d", i), 32'(v), 32'd0);
    end

    // Integrate and fire on neuron 0, no refractory hold
    set_cfg(10000, 3277, 30000, 5000, 0);
    for (int s = 0; s < 5; s++) begin
      run_step(sp);
      read_v(0, v);
      check($sformatf("if_spk_s%0d", s+1), 32'(sp), (s == 3) ? 32'd1 : 32'd0);
      check($sformatf("if_v0_s%0d", s+1), 32'(v), (s == 4) ? 32'd14750 : 32'(exp_v[s]));
    end
    for (int i = 1; i < N; i++) begin
      read_v(i, v);
      check($sformatf("if_other_v%0d", i), 32'(v), 32'd0);
    end

    // Refractory period of two timesteps
    do_reset();
    set_cfg(10000, 3277, 30000, 5000, 2);
    for (int s = 0; s < 7; s++) begin
      run_step(sp);
      read_v(0, v);
      check($sformatf("ref_spk_s%0d", s+1), 32'(sp), 32'(exp_sp[s]));
      check($sformatf("ref_v0_s%0d", s+1), 32'(v), 32'(exp_v[s]));
    end

    // Saturated sum still compared against threshold
    do_reset();
    set_cfg(40000, 3277, 65535, 5000, 0);
    run_step(sp);
    read_v(0, v);
    check("sat_spk_s1", 32'(sp), 32'd0);
    check("sat_v0_s1", 32'(v), 32'd40000);
    run_step(sp);
    read_v(0, v);
    check("sat_spk_s2", 32'(sp), 32'd1);
    check("sat_v0_s2", 32'(v), 32'd5000);

    // Backpressure, latency, shadowing of inputs, write-first readback
    do_reset();
    set_cfg(10000, 3277, 30000, 5000, 0);
    rd_idx = '0;
    step_valid = 1'b1;
    @(posedge clk); #1;
    step_valid = 1'b0;
    threshold = '0;
    input_current = '1;
    n = 0;
    while (n < 50) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) check("wr_first_v0", 32'(rd_potential), 32'd10000);
      if (spike_valid) break;
    end
    check("latency", 32'(n), 32'(N + 1));
    check("bp_spikes", 32'(spikes), 32'd0);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (spikes !== '0 || step_ready !== 1'b0 || spike_valid !== 1'b1) bad++;
    end
    check("bp_hold", 32'(bad), 32'd0);
    spike_ready = 1'b1;
    @(posedge clk); #1;
    spike_ready = 1'b0;
    check("bp_release_valid", 32'(spike_valid), 32'd0);
    check("bp_release_ready", 32'(step_ready), 32'd1);
    read_v(0, v);
    check("bp_v0", 32'(v), 32'd10000);
    read_v(1, v);
    check("bp_v1", 32'(v), 32'd0);

    // Threshold zero fires every non-refractory neuron
    set_cfg(10000, 3277, 0, 5000, 0);
    run_step(sp);
    check("thr0_spikes", 32'(sp), 32'hFF);
    read_v(3, v);
    check("thr0_v3", 32'(v), 32'd5000);

    // Reset while neuron 3 is being processed
    set_cfg(10000, 3277, 30000, 5000, 0);
    step_valid = 1'b1;
    @(posedge clk); #1;
    step_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_step_ready", 32'(step_ready), 32'd1);
    check("abort_spike_valid", 32'(spike_valid), 32'd0);
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (spike_valid !== 1'b0) bad++;
    end
    check("abort_no_valid", 32'(bad), 32'd0);
    for (int i = 0; i < N; i++) begin
      read_v(i, v);
      check($sformatf("abort_v%0d", i), 32'(v), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
